// File: rtl/tff_div_pkg.sv
// Shared definitions for the programmable T-flip-flop clock-enable divider.
// Holds the divisor-change FSM encoding and the divisor clamp rule.
package tff_div_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } state_e;

   // Divisors of 0 or 1 cannot form a two-phase period, so they run as 2.
   function automatic logic [31:0] clamp_div(input logic [31:0] v);
      return (v < 32'd2) ? 32'd2 : v;
   endfunction

endpackage

// File: rtl/tff_divider_cell.sv
// Synchronous-reset toggle stage driving the divided level and its complement.
// load_zero wins over t so a newly applied divisor always starts from q=0.
module tff_cell (
   input  logic clk,
   input  logic reset,
   input  logic t,
   input  logic load_zero,
   output logic q,
   output logic q_bar
);

   logic q_q;
   logic q_d;

   always_comb begin
      q_d = q_q;
      if (load_zero) begin
         q_d = 1'b0;
      end else if (t) begin
         q_d = ~q_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q     = q_q;
   assign q_bar = ~q_q;

endmodule

// File: rtl/tff_divider.sv
// Programmable clock-enable divider: phase counter, tick strobe and a
// load/ack handshake that swaps the divisor only at a period boundary.
module tff_divider
   import tff_div_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int RESET_DIV = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] div_val,
   input  logic             div_load,
   output logic             div_ack,
   output logic             busy,
   output logic [WIDTH-1:0] cnt,
   output logic             q,
   output logic             q_bar,
   output logic             tick
);

   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [WIDTH-1:0] RESET_D = WIDTH'(clamp_div(32'(RESET_DIV)));

   state_e           state_q, state_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic             ack_q, ack_d;
   logic [WIDTH-1:0] half;
   logic             wrap;
   logic             t;
   logic             load_zero;

   assign half = div_q >> 1;
   assign wrap = en && (cnt_q == div_q - ONE);

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      pend_d    = pend_q;
      cnt_d     = cnt_q;
      tick_d    = 1'b0;
      ack_d     = 1'b0;
      t         = 1'b0;
      load_zero = 1'b0;

      if (en) begin
         t      = (cnt_q == half - ONE) || (cnt_q == div_q - ONE);
         cnt_d  = wrap ? '0 : cnt_q + ONE;
         tick_d = wrap;
      end

      // A load on the same edge as an apply opportunity only recaptures,
      // so the swap is pushed to the next boundary.
      case (state_q)
         IDLE: begin
            if (div_load) begin
               pend_d  = div_val;
               state_d = PEND;
            end
         end
         PEND: begin
            if (div_load) begin
               pend_d = div_val;
            end else if (wrap || !en) begin
               div_d     = WIDTH'(clamp_div(32'(pend_q)));
               cnt_d     = '0;
               load_zero = 1'b1;
               ack_d     = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         div_q   <= RESET_D;
         cnt_q   <= '0;
         tick_q  <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         tick_q  <= tick_d;
         ack_q   <= ack_d;
      end
   end

   // The pending value is only meaningful in PEND, so it carries no reset.
   always_ff @(posedge clk) begin
      pend_q <= pend_d;
   end

   tff_cell u_cell (
      .clk       (clk),
      .reset     (reset),
      .t         (t),
      .load_zero (load_zero),
      .q         (q),
      .q_bar     (q_bar)
   );

   assign cnt     = cnt_q;
   assign tick    = tick_q;
   assign div_ack = ack_q;
   assign busy    = (state_q == PEND);

endmodule

// File: doc/tff_divider.md
Name: tff_divider

Overview:
- Parametrised programmable clock-enable divider built around a T flip-flop output stage.
- Generates a divided square-wave level `q`/`q_bar` and a one-cycle `tick` strobe every D enabled cycles.
- The divisor D is runtime-programmable through a load/ack handshake. A new divisor takes effect only at a period boundary, so `q` never glitches.
- Sits between the system clock and downstream counters or slow-peripheral logic as a clock-enable source. It is not a clock generator.

Parameters:
- WIDTH, 8: width of divisor and counter; D ranges 2..2^WIDTH-1.
- RESET_DIV, 4: divisor loaded on reset; values 0 and 1 are clamped to 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous reset, active-high.
- en  input  1  count enable; when low, all counting state holds.
- div_val  input  WIDTH  requested divisor; sampled when div_load=1.
- div_load  input  1  single-cycle request to change the divisor.
- div_ack  output  1  one-cycle pulse on the edge where the pending divisor becomes active.
- busy  output  1  high while a divisor change is pending.
- cnt  output  WIDTH  phase counter, 0..D-1.
- q  output  1  divided output; low for floor(D/2) cycles, then high for ceil(D/2) cycles.
- q_bar  output  1  complement of q.
- tick  output  1  registered one-cycle strobe, high in the cycle cnt returns to 0.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, and has priority over everything else.
- Reset values: cnt=0, q=0 (q_bar=1), tick=0, div_ack=0, busy=0, state=IDLE, active divisor D=clamp(RESET_DIV).
- Clamp rule: any divisor value of 0 or 1 is treated as 2. Both D and L=D>>1 are WIDTH bits wide; L is at least 1.
- Counting, on an enabled edge (en=1):
  - Wrap edge: if cnt==D-1, then cnt<=0, otherwise cnt<=cnt+1.
  - q toggles (T=1) when cnt==L-1 or cnt==D-1; otherwise it holds.
  - tick<=1 on the wrap edge, otherwise 0. The tick period is exactly D enabled cycles.
- en=0: cnt and q hold, and tick<=0. Re-asserting en resumes from the held phase with no skipped or extra cycle.
- Divisor-change FSM has two states, IDLE and PEND.
  - IDLE, div_load=1: capture div_val into the pending register, go to PEND, busy=1.
  - PEND, div_load=1: recapture div_val (last write wins), stay in PEND, no apply that edge.
  - PEND, div_load=0, apply condition true: apply, go to IDLE, busy=0.
  - Apply condition: (en=1 and wrap edge) or en=0.
  - On apply: D<=clamp(pending), cnt<=0, q<=0, div_ack<=1 for exactly one cycle. If the apply happens on a wrap edge, tick is still asserted.
  - A div_load arriving on the same edge as a wrap is only captured; the new divisor is applied at the following wrap edge.
- Mid-operation reset discards any pending divisor; no div_ack is issued.
- No combinational path from inputs to outputs. All outputs are registered except q_bar, which is ~q.

Decomposition:
- Shared package/include tff_div_pkg holds:
  - FSM state encoding localparams: IDLE=1'b0, PEND=1'b1.
  - Clamp function: returns 2 for inputs below 2.
- Sub-module tff_cell (clk, reset, t, q, q_bar): a synchronous-reset toggle stage that drives q/q_bar from the computed toggle condition. A new divisor forces q to 0 through a load-zero input on tff_cell.
- The counter, FSM and tick logic stay in tff_divider.

Test Plan:
- Reset release, RESET_DIV=4, en=1 held: cnt 0,1,2,3,0,…; q 0,0,1,1,0,…; tick high whenever cnt==0 after a wrap, period 4; div_ack=0, busy=0.
- div_load with div_val=5 at cnt=1 (D=4): busy=1 until the wrap edge. div_ack pulses in the cycle cnt becomes 0. Next periods: q low 2 cycles, high 3; tick period 5; no short high/low pulse on q.
- div_val=0, then div_val=1 (each loaded and applied): behaves as D=2; q toggles every cycle, tick every 2 cycles. Max value 2^WIDTH-1=255 gives tick period 255.
- en low at cnt=2 (D=4) for 3 cycles: cnt=2 and q hold, tick=0; resuming yields a wrap exactly 2 enabled cycles later. A div_load of 6 issued while en=0 applies on the next edge: div_ack=1, cnt=0, q=0.
- Back-to-back div_load of 3, 7, 6 on consecutive cycles during D=4: exactly one div_ack, active D=6 after the next wrap. A load coincident with a wrap is deferred to the following wrap.
- reset asserted while busy=1: next cycle all outputs at their reset values, D=RESET_DIV, and div_ack never pulses for the discarded request.
